// File: rtl/clock_timekeeper.sv
// clock_timekeeper: one-second prescaler, 24-hour BCD time of day, set-mode
// state machine with Up-button auto-repeat, 12/24-hour output conversion and
// per-digit blink enables for a six-digit display.
module clock_timekeeper #(
    parameter int CLK_FREQ_HZ          = 25000000,
    parameter int MODE_24H             = 1,
    parameter int REPEAT_DELAY_CYCLES  = 12500000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Set_Pulse,
    input  logic       i_Up_Pulse,
    input  logic       i_Up_Held,
    output logic [1:0] o_Hour_Tens,
    output logic [3:0] o_Hour_Units,
    output logic [2:0] o_Min_Tens,
    output logic [3:0] o_Min_Units,
    output logic [2:0] o_Sec_Tens,
    output logic [3:0] o_Sec_Units,
    output logic       o_PM,
    output logic [1:0] o_State,
    output logic [5:0] o_Digit_Enable,
    output logic       o_Dot,
    output logic       o_Tick_1Hz
);
    // state    | meaning
    // RUN      | time advances once per prescaler wrap, all digits lit
    // SET_HOUR | time frozen, Up increments hours, hour digits blink
    // SET_MIN  | time frozen, Up increments minutes, minute digits blink
    // SET_SEC  | time frozen, Up clears seconds, second digits blink

    localparam int PW   = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ_HZ - 1);
    localparam logic [PW-1:0] P_Q1   = PW'(CLK_FREQ_HZ / 4);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_FREQ_HZ / 2);
    localparam logic [PW-1:0] P_Q3   = PW'((3 * CLK_FREQ_HZ) / 4);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_SET_HOUR = 2'd1,
        S_SET_MIN  = 2'd2,
        S_SET_SEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [RW-1:0] rep_cnt_q;
    logic          repeating_q;
    logic          strobed_q;
    logic [5:0]    hour_q;
    logic [6:0]    min_q;
    logic [6:0]    sec_q;

    logic tick, blink, in_set, counting, rep_strobe, inc_evt;

    // BCD 00..59 increment with wrap; tens in [6:4], units in [3:0]
    function automatic logic [6:0] inc60(input logic [6:0] v);
        if (v == 7'h59)         inc60 = 7'h00;
        else if (v[3:0] == 4'd9) inc60 = {v[6:4] + 3'd1, 4'd0};
        else                     inc60 = {v[6:4], v[3:0] + 4'd1};
    endfunction

    // BCD 00..23 increment with wrap
    function automatic logic [5:0] inc24(input logic [5:0] v);
        if (v == 6'h23)          inc24 = 6'h00;
        else if (v[3:0] == 4'd9) inc24 = {v[5:4] + 2'd1, 4'd0};
        else                     inc24 = {v[5:4], v[3:0] + 4'd1};
    endfunction

    assign tick       = (presc_q == P_LAST);
    assign blink      = ((presc_q >= P_Q1) && (presc_q < P_HALF)) || (presc_q >= P_Q3);
    assign in_set     = (state_q != S_RUN);
    assign counting   = in_set && i_Up_Held && !i_Set_Pulse;
    assign rep_strobe = counting && (repeating_q ? (rep_cnt_q == R_PER) : (rep_cnt_q == R_DLY));
    // a release pulse that ends a hold which already auto-repeated is swallowed
    assign inc_evt    = in_set && !i_Set_Pulse && ((i_Up_Pulse && !strobed_q) || rep_strobe);

    // state register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state_q <= S_RUN;
        else            state_q <= state_d;
    end

    // next state, blink gating and dot drive
    always_comb begin
        state_d        = state_q;
        o_Digit_Enable = 6'b111111;
        o_Dot          = 1'b1;
        if (i_Set_Pulse) begin
            unique case (state_q)
                S_RUN:      state_d = S_SET_HOUR;
                S_SET_HOUR: state_d = S_SET_MIN;
                S_SET_MIN:  state_d = S_SET_SEC;
                S_SET_SEC:  state_d = S_RUN;
            endcase
        end
        unique case (state_q)
            S_RUN:      o_Dot = (presc_q < P_HALF);
            S_SET_HOUR: if (blink) o_Digit_Enable[5:4] = 2'b00;
            S_SET_MIN:  if (blink) o_Digit_Enable[3:2] = 2'b00;
            S_SET_SEC:  if (blink) o_Digit_Enable[1:0] = 2'b00;
        endcase
    end

    // prescaler runs in every state; leaving SET_SEC restarts the second
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)                              presc_q <= '0;
        else if (state_q == S_SET_SEC && i_Set_Pulse) presc_q <= '0;
        else if (tick)                               presc_q <= '0;
        else                                         presc_q <= presc_q + PW'(1);
    end

    // Up-held counter: initial delay, then periodic strobes; tracks whether the hold repeated
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rep_cnt_q   <= '0;
            repeating_q <= 1'b0;
            strobed_q   <= 1'b0;
        end else begin
            if (!counting) begin
                rep_cnt_q   <= '0;
                repeating_q <= 1'b0;
            end else if (rep_strobe) begin
                rep_cnt_q   <= '0;
                repeating_q <= 1'b1;
            end else begin
                rep_cnt_q   <= rep_cnt_q + RW'(1);
            end

            if (i_Set_Pulse)                strobed_q <= 1'b0;
            else if (rep_strobe)            strobed_q <= 1'b1;
            else if (in_set && i_Up_Pulse)  strobed_q <= 1'b0;
            else if (counting && !repeating_q) strobed_q <= 1'b0;
        end
    end

    // time of day: carry chain in RUN, single-field edits in SET states
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else if (state_q == S_RUN && tick) begin
            sec_q <= inc60(sec_q);
            if (sec_q == 7'h59) begin
                min_q <= inc60(min_q);
                if (min_q == 7'h59) hour_q <= inc24(hour_q);
            end
        end else if (inc_evt) begin
            unique case (state_q)
                S_SET_HOUR: hour_q <= inc24(hour_q);
                S_SET_MIN:  min_q  <= inc60(min_q);
                S_SET_SEC:  sec_q  <= 7'h00;
                default:    ;
            endcase
        end
    end

    logic [4:0] hour_bin, h12;

    // display-mode hour conversion (00 -> 12 AM, 13..23 -> 01..11 PM)
    always_comb begin
        hour_bin = ({3'b000, hour_q[5:4]} * 5'd10) + {1'b0, hour_q[3:0]};
        h12      = hour_bin;
        if (hour_bin == 5'd0)       h12 = 5'd12;
        else if (hour_bin > 5'd12)  h12 = hour_bin - 5'd12;
        if (MODE_24H != 0) begin
            o_Hour_Tens  = hour_q[5:4];
            o_Hour_Units = hour_q[3:0];
            o_PM         = 1'b0;
        end else begin
            o_Hour_Tens  = (h12 >= 5'd10) ? 2'd1 : 2'd0;
            o_Hour_Units = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : h12[3:0];
            o_PM         = (hour_bin >= 5'd12);
        end
    end

    assign o_Min_Tens  = min_q[6:4];
    assign o_Min_Units = min_q[3:0];
    assign o_Sec_Tens  = sec_q[6:4];
    assign o_Sec_Units = sec_q[3:0];
    assign o_State     = state_q;
    assign o_Tick_1Hz  = tick;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: two instances (24-hour and 12-hour) share the
// inputs; a seconds-of-day reference model predicts every cycle's outputs.
module tb_clock_timekeeper;
    localparam int N = 8;
    localparam int D = 6;
    localparam int P = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_p = 1'b0, up_p = 1'b0, up_h = 1'b0;

    logic [1:0] a_ht, b_ht;
    logic [3:0] a_hu, b_hu, a_mu, b_mu, a_su, b_su;
    logic [2:0] a_mt, b_mt, a_st, b_st;
    logic       a_pm, b_pm, a_dot, b_dot, a_tick, b_tick;
    logic [1:0] a_state, b_state;
    logic [5:0] a_den, b_den;
    logic [30:0] a_vec, b_vec;

    assign a_vec = {a_ht, a_hu, a_mt, a_mu, a_st, a_su, a_pm, a_state, a_den, a_dot, a_tick};
    assign b_vec = {b_ht, b_hu, b_mt, b_mu, b_st, b_su, b_pm, b_state, b_den, b_dot, b_tick};

    clock_timekeeper #(.CLK_FREQ_HZ(N), .MODE_24H(1), .REPEAT_DELAY_CYCLES(D),
                       .REPEAT_PERIOD_CYCLES(P)) dut_a (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Set_Pulse(set_p), .i_Up_Pulse(up_p),
        .i_Up_Held(up_h), .o_Hour_Tens(a_ht), .o_Hour_Units(a_hu), .o_Min_Tens(a_mt),
        .o_Min_Units(a_mu), .o_Sec_Tens(a_st), .o_Sec_Units(a_su), .o_PM(a_pm),
        .o_State(a_state), .o_Digit_Enable(a_den), .o_Dot(a_dot), .o_Tick_1Hz(a_tick));

    clock_timekeeper #(.CLK_FREQ_HZ(N), .MODE_24H(0), .REPEAT_DELAY_CYCLES(D),
                       .REPEAT_PERIOD_CYCLES(P)) dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Set_Pulse(set_p), .i_Up_Pulse(up_p),
        .i_Up_Held(up_h), .o_Hour_Tens(b_ht), .o_Hour_Units(b_hu), .o_Min_Tens(b_mt),
        .o_Min_Units(b_mu), .o_Sec_Tens(b_st), .o_Sec_Units(b_su), .o_PM(b_pm),
        .o_State(b_state), .o_Digit_Enable(b_den), .o_Dot(b_dot), .o_Tick_1Hz(b_tick));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [61:0] exp_q[$];

    // reference model: time as seconds of day, state as 0..3, hold length in cycles
    int tsec = 0, mst = 0, mp = 0, mhl = 0;
    bit msup = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tsec = 0; mst = 0; mp = 0; mhl = 0; msup = 1'b0;
    endtask

    task automatic model_step(input bit sp, input bit up, input bit held);
        int hh, mm, ss, hl_n;
        bit tk, strobe, incr;
        hh = tsec / 3600; mm = (tsec / 60) % 60; ss = tsec % 60;
        tk = (mp == N - 1);
        hl_n = (mst != 0 && held && !sp) ? mhl + 1 : 0;
        strobe = (hl_n == D) || (hl_n > D && ((hl_n - D) % P) == 0);
        incr = (mst != 0) && !sp && ((up && !msup) || strobe);
        if (mst == 0 && tk) tsec = (tsec + 1) % 86400;
        else if (incr) begin
            if (mst == 1)      hh = (hh + 1) % 24;
            else if (mst == 2) mm = (mm + 1) % 60;
            else               ss = 0;
            tsec = hh * 3600 + mm * 60 + ss;
        end
        if (sp)                      msup = 1'b0;
        else if (strobe)             msup = 1'b1;
        else if (mst != 0 && up)     msup = 1'b0;
        else if (hl_n > 0 && hl_n < D) msup = 1'b0;
        mp = (mst == 3 && sp) ? 0 : (mp + 1) % N;
        if (sp) mst = (mst + 1) % 4;
        mhl = hl_n;
    endtask

    function automatic logic [30:0] exp_vec(input bit mode24);
        int hh, mm, ss, hd;
        bit pm, blink, dot, tk;
        logic [5:0] den;
        hh = tsec / 3600; mm = (tsec / 60) % 60; ss = tsec % 60;
        if (mode24) begin
            hd = hh; pm = 1'b0;
        end else begin
            hd = (hh == 0) ? 12 : ((hh > 12) ? hh - 12 : hh);
            pm = (hh >= 12);
        end
        blink = (mp >= N / 4 && mp < N / 2) || (mp >= (3 * N) / 4);
        den = 6'h3f;
        if (mst != 0 && blink) den[7 - 2 * mst -: 2] = 2'b00;
        dot = (mst == 0) ? (mp < N / 2) : 1'b1;
        tk = (mp == N - 1);
        exp_vec = {2'(hd / 10), 4'(hd % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10),
                   4'(ss % 10), pm, 2'(mst), den, dot, tk};
    endfunction

    // monitor: one expected record per active edge, compared just after it
    initial begin
        logic [61:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_24h", 64'(a_vec), 64'(e[61:31]));
                check("cycle_12h", 64'(b_vec), 64'(e[30:0]));
            end
        end
    end

    task automatic step(input bit sp, input bit up, input bit held);
        @(negedge clk);
        set_p = sp; up_p = up; up_h = held;
        model_step(sp, up, held);
        exp_q.push_back({exp_vec(1'b1), exp_vec(1'b0)});
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0);
        exp_q.push_back({exp_vec(1'b1), exp_vec(1'b0)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; set_p = 1'b0; up_p = 1'b0; up_h = 1'b0;
        model_reset();
        #1;
        check("async_reset_24h", 64'(a_vec), 64'(exp_vec(1'b1)));
        check("async_reset_12h_hour", 64'({b_ht, b_hu, b_pm}), 64'({2'd1, 4'd2, 1'b0}));
        exp_q.push_back({exp_vec(1'b1), exp_vec(1'b0)});
        @(negedge clk);
        exp_q.push_back({exp_vec(1'b1), exp_vec(1'b0)});
        release_reset();
    endtask

    task automatic first_tick_after_exit(input string name);
        int cyc;
        step(1'b1, 1'b0, 1'b0);
        sample();
        cyc = 1;
        while (!a_tick && cyc < 3 * N) begin
            step(1'b0, 1'b0, 1'b0);
            sample();
            cyc++;
        end
        check(name, 64'(cyc), 64'(N));
    endtask

    initial begin
        int k, nt, nd;
        bit held_r, prev_held, sp, up;
        int pulses[4] = '{11, 1, 1, 10};
        logic [6:0] h12e[4] = '{{2'd1, 4'd1, 1'b0}, {2'd1, 4'd2, 1'b1},
                                {2'd0, 4'd1, 1'b1}, {2'd1, 4'd1, 1'b1}};

        model_reset();
        #2;
        check("reset_24h", 64'(a_vec), 64'(exp_vec(1'b1)));
        check("reset_12h", 64'(b_vec), 64'(exp_vec(1'b0)));
        check("reset_12h_hour", 64'({b_ht, b_hu, b_pm}), 64'({2'd1, 4'd2, 1'b0}));
        @(negedge clk);
        release_reset();

        // preload 23:59:00 via the set path
        step(1'b1, 1'b0, 1'b0);
        repeat (23) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        k = 0;
        while (tsec != 86398 && k < 1000) begin step(1'b0, 1'b0, 1'b0); k++; end
        check("reach_23_59_58", 64'(k < 1000), 64'(1));

        nt = 0; nd = 0;
        repeat (16) begin
            step(1'b0, 1'b0, 1'b0);
            sample();
            nt += int'(a_tick);
            nd += int'(a_dot);
        end
        check("wrap_tick_count", 64'(nt), 64'(2));
        check("wrap_dot_count", 64'(nd), 64'(8));
        check("wrap_time_zero", 64'({a_ht, a_hu, a_mt, a_mu, a_st, a_su}), 64'(0));

        // 12-hour conversion while stepping the hour
        step(1'b1, 1'b0, 1'b0);
        sample();
        check("h12_00", 64'({b_ht, b_hu, b_pm}), 64'({2'd1, 4'd2, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            repeat (pulses[i]) step(1'b0, 1'b1, 1'b0);
            sample();
            check($sformatf("h12_step%0d", i), 64'({b_ht, b_hu, b_pm}), 64'(h12e[i]));
        end
        check("hour_23", 64'({a_ht, a_hu}), 64'(6'h23));
        step(1'b0, 1'b1, 1'b0);
        sample();
        check("hour_wrap", 64'({a_ht, a_hu, a_mt, a_mu}), 64'(0));

        // Set and Up together: state advances, hour untouched
        step(1'b1, 1'b1, 1'b0);
        sample();
        check("set_up_same_cycle", 64'({a_state, a_ht, a_hu}), 64'({2'd2, 6'h00}));

        repeat (59) step(1'b0, 1'b1, 1'b0);
        sample();
        check("min_59", 64'({a_mt, a_mu}), 64'(7'h59));
        step(1'b0, 1'b1, 1'b0);
        sample();
        check("min_wrap", 64'({a_ht, a_hu, a_mt, a_mu}), 64'(0));

        // auto-repeat: DELAY + 3*PERIOD held cycles then release pulse -> +4
        repeat (D + 3 * P) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        sample();
        check("auto_repeat_plus4", 64'({a_mt, a_mu}), 64'(7'h04));

        // run to :37, then clear seconds in SET_SEC
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        k = 0;
        while (tsec % 60 != 37 && k < 1000) begin step(1'b0, 1'b0, 1'b0); k++; end
        check("reach_sec_37", 64'(k < 1000), 64'(1));
        repeat (3) step(1'b1, 1'b0, 1'b0);
        sample();
        check("sec_frozen_37", 64'({a_state, a_st, a_su}), 64'({2'd3, 7'h37}));
        step(1'b0, 1'b1, 1'b0);
        sample();
        check("sec_clear", 64'({a_st, a_su, a_mt, a_mu}), 64'({7'h00, 7'h04}));
        first_tick_after_exit("first_tick_exit1");

        // reset mid SET_MIN with auto-repeat running
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (D + 1) step(1'b0, 1'b0, 1'b1);
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        first_tick_after_exit("first_tick_exit2");

        // randomized traffic
        held_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                held_r = 1'b0;
            end
            prev_held = held_r;
            if ($urandom_range(0, 29) == 0) held_r = ~held_r;
            sp = ($urandom_range(0, 39) == 0);
            up = (prev_held && !held_r) ? 1'b1 : ($urandom_range(0, 15) == 0);
            step(sp, up, held_r);
        end

        step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Parametrised timekeeping core for the FPGA clock: one-second prescaler, BCD hours/minutes/seconds counters, a set-mode state machine with button auto-repeat, selectable 12/24-hour output, and per-digit blink enables for a six-digit display. It sits between the button debouncers (release pulses plus held levels) and the display multiplexer. It replaces the separate control-unit, counter and blink-gating glue with one block.

## Interface
- CLK_FREQ_HZ, 25000000: i_Clock frequency; prescaler terminal count is CLK_FREQ_HZ-1.
- MODE_24H, 1: 1 gives 00–23 hour output; 0 gives 12-hour output (01–12) with o_PM.
- REPEAT_DELAY_CYCLES, 12500000: continuous Up-held cycles before auto-repeat starts.
- REPEAT_PERIOD_CYCLES, 5000000: cycles between auto-repeat increments.
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Set_Pulse  in  1  one-cycle pulse on Set button release.
- i_Up_Pulse  in  1  one-cycle pulse on Up button release.
- i_Up_Held  in  1  debounced level, high while Up is pressed.
- o_Hour_Tens  out  2  BCD hour tens (display-mode converted).
- o_Hour_Units  out  4  BCD hour units.
- o_Min_Tens  out  3 / o_Min_Units  out  4  BCD minutes.
- o_Sec_Tens  out  3 / o_Sec_Units  out  4  BCD seconds.
- o_PM  out  1  high for internal hours 12–23 when MODE_24H=0; always 0 when MODE_24H=1.
- o_State  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- o_Digit_Enable  out  6  bits [5:4] hour, [3:2] min, [1:0] sec; 1 = lit.
- o_Dot  out  1  colon/dot drive.
- o_Tick_1Hz  out  1  one-cycle pulse at each prescaler wrap.

## Operation
- Internal time is always 24-hour BCD. The output conversion is combinational from registers.
  - MODE_24H=0 conversion: hour 00 becomes 12 AM; 01–11 are unchanged AM; 12 is 12 PM; 13–23 become 01–11 PM.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 in every state.
  - o_Tick_1Hz is high in the cycle the count equals CLK_FREQ_HZ-1.
  - The prescaler is cleared on the SET_SEC→RUN transition, so the first tick follows exactly CLK_FREQ_HZ cycles later.
- Blink phase: high when prescaler ≥ CLK_FREQ_HZ/4 and < CLK_FREQ_HZ/2, or when ≥ 3·CLK_FREQ_HZ/4. This gives 2 Hz.
- RUN:
  - Each tick increments seconds 00–59.
  - Carry into minutes 00–59, then hours 00–23; 23:59:59 wraps to 00:00:00.
  - o_Digit_Enable = 6'b111111.
  - o_Dot = 1 while prescaler < CLK_FREQ_HZ/2, otherwise 0.
- State transitions on i_Set_Pulse: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- SET states:
  - Time counting is frozen; ticks are ignored.
  - o_Dot = 1 constantly.
  - The selected field's two enable bits are 0 while the blink phase is high; all other bits are 1.
- Increment event: i_Up_Pulse, or an auto-repeat strobe, in a SET state.
  - SET_HOUR: hour +1, 23→00, no carry.
  - SET_MIN: minute +1, 59→00, no carry.
  - SET_SEC: seconds cleared to 00, no carry.
  - In RUN, increment events are ignored.
- Auto-repeat:
  - A held counter counts while i_Up_Held=1 in a SET state.
  - At REPEAT_DELAY_CYCLES it strobes, then strobes every REPEAT_PERIOD_CYCLES.
  - The counter clears when i_Up_Held=0 or on any state change.
  - The release pulse that ends a hold that produced at least one strobe is suppressed. No double increment.
- Simultaneous events:
  - i_Set_Pulse and an increment in the same cycle: the state advances and the increment is dropped.
  - Tick and i_Set_Pulse in RUN in the same cycle: the tick is applied and the state still advances.

## Timing
- Reset (async assert, sync release use): time 00:00:00, state RUN, prescaler 0, held counter 0.
  - Outputs during reset: o_Tick_1Hz=0, o_Digit_Enable=6'b111111, o_Dot=1.
  - With MODE_24H=0, hour outputs read 12 and o_PM=0.
- Counter and state updates land one cycle after the qualifying input or tick cycle. Outputs follow registers with zero added latency.
- Reset mid-setting returns to RUN with time cleared; no partial increment survives.
- Prescaler width is $clog2(CLK_FREQ_HZ). The repeat counter width covers max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES).

## Test plan
- CLK_FREQ_HZ=8, preload 23:59:58 via the SET path, RUN 16 cycles -> exactly two o_Tick_1Hz pulses; time reads 00:00:00; o_Dot is high for 4 cycles of each 8.
- MODE_24H=0, step internal hour 00, 11, 12, 13, 23 -> outputs 12 AM, 11 AM, 12 PM, 01 PM, 11 PM (o_PM 0, 0, 1, 1, 1).
- SET_HOUR at 23, one i_Up_Pulse -> hour 00 with minutes unchanged. In SET_MIN at 59, one pulse -> minute 00 with hour unchanged. In SET_SEC at 37, one pulse -> 00.
- i_Up_Held high for DELAY + 3·PERIOD cycles in SET_MIN, then released with a pulse -> minute advanced by exactly 4.
- i_Set_Pulse and i_Up_Pulse in the same cycle in SET_HOUR -> state SET_MIN; hour unchanged.
- Assert i_Reset_n=0 mid-SET_MIN with auto-repeat active -> immediate 00:00:00, RUN, all digits enabled. After SET_SEC→RUN exit, the first tick occurs exactly CLK_FREQ_HZ cycles later.
